// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_edge block.
// Edge-selection enum plus a helper that decides whether a channel event sets its capture bit.
package debounce_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_type_t;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    function automatic logic edge_hit(input edge_type_t kind, input logic rise, input logic fall);
        logic hit;
        case (kind)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            default:   hit = rise | fall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single-channel debouncer: a stability counter, the accepted level, and registered rise/fall pulses.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive samples that differ from the current one.
module debounce_chan #(
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 differ;
    logic                 at_last;

    assign differ  = din_i ^ level_q;
    assign at_last = (cnt_q == CNT_LAST);

    // Any sample matching the current level restarts the count, which also rejects short bounces.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (differ) begin
            if (at_last) begin
                level_d = din_i;
                rise_d  = din_i;
                fall_d  = ~din_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_edge.sv
// Multi-channel debouncer with rise/fall pulses, a sticky edge-capture register and a masked interrupt.
// Expects indata already synchronized to clk; no synchronizer stage lives here.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int         WIDTH           = 4,
    parameter int         CNT_WIDTH       = 20,
    parameter int         DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter edge_type_t EDGE_TYPE       = EDGE_BOTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] indata,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] edgecap,
    input  logic [WIDTH-1:0] edgecap_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_cycles
        $error("debounce_edge: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end

    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] set_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .CNT_WIDTH      (CNT_WIDTH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .din_i  (indata[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );

        assign set_vec[i] = edge_hit(EDGE_TYPE, rise[i], fall[i]);
    end

    // Set has priority over clear so an edge arriving with a clear strobe is never dropped.
    always_comb begin
        edgecap_d = set_vec | (edgecap_q & ~edgecap_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap_q <= '0;
        end else begin
            edgecap_q <= edgecap_d;
        end
    end

    assign edgecap = edgecap_q;
    assign irq     = |(edgecap_q & irq_mask);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_BOTH).
// Observed vector is {level, rise, fall, edgecap, irq}; expectations are queued per step and popped after the edge.
module tb_debounce_edge;
    import debounce_pkg::*;

    localparam int W = 17;

    logic       clk;
    logic       reset;
    logic [3:0] indata;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] edgecap;
    logic [3:0] edgecap_clr;
    logic [3:0] irq_mask;
    logic       irq;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    debounce_edge #(
        .WIDTH          (4),
        .CNT_WIDTH      (3),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (EDGE_BOTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .indata     (indata),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .edgecap    (edgecap),
        .edgecap_clr(edgecap_clr),
        .irq_mask   (irq_mask),
        .irq        (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ex(input logic [3:0] l, input logic [3:0] r,
                                        input logic [3:0] f, input logic [3:0] e, input logic i);
        return {l, r, f, e, i};
    endfunction

    task automatic compare(input string tag);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {level, rise, fall, edgecap, irq};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
        end
    endtask

    // one clock: drive inputs, queue the expectation, sample just after the edge
    task automatic cyc(input string tag, input logic [3:0] din, input logic [3:0] clr,
                       input logic [W-1:0] exp_v);
        indata      = din;
        edgecap_clr = clr;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // compare without a clock edge (async reset, combinational irq)
    task automatic check_now(input string tag, input logic [W-1:0] exp_v);
        exp_q.push_back(exp_v);
        #1;
        compare(tag);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        indata      = 4'b0000;
        edgecap_clr = 4'b0000;
        irq_mask    = 4'b0000;

        check_now("reset_state", ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_now("post_release", ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));

        // ch0 clean step, latency and irq masking
        irq_mask = 4'b0001;
        for (int i = 0; i < 3; i++) cyc("s1_count", 4'b0001, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s1_rise", 4'b0001, 4'b0000, ex(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0));
        cyc("s1_cap", 4'b0001, 4'b0000, ex(4'b0001, 4'h0, 4'h0, 4'b0001, 1'b1));
        irq_mask = 4'b0000;
        check_now("s1_irq_masked", ex(4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0));
        cyc("s1_clr", 4'b0001, 4'b0001, ex(4'b0001, 4'h0, 4'h0, 4'h0, 1'b0));

        // ch1 bounce with 2-cycle highs never accepted
        for (int i = 0; i < 8; i++) begin
            cyc("s2_bounce", ((i % 4) < 2) ? 4'b0011 : 4'b0001, 4'b0000,
                ex(4'b0001, 4'h0, 4'h0, 4'h0, 1'b0));
        end

        // ch2 goes high, then a low with one glitch restarting the count
        for (int i = 0; i < 3; i++) cyc("s3_up_count", 4'b0101, 4'b0000, ex(4'b0001, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s3_up_rise", 4'b0101, 4'b0000, ex(4'b0101, 4'b0100, 4'h0, 4'h0, 1'b0));
        cyc("s3_low1", 4'b0001, 4'b0000, ex(4'b0101, 4'h0, 4'h0, 4'b0100, 1'b0));
        cyc("s3_low2", 4'b0001, 4'b0000, ex(4'b0101, 4'h0, 4'h0, 4'b0100, 1'b0));
        cyc("s3_glitch", 4'b0101, 4'b0000, ex(4'b0101, 4'h0, 4'h0, 4'b0100, 1'b0));
        for (int i = 0; i < 3; i++) cyc("s3_recount", 4'b0001, 4'b0000, ex(4'b0101, 4'h0, 4'h0, 4'b0100, 1'b0));
        cyc("s3_fall", 4'b0001, 4'b0000, ex(4'b0001, 4'h0, 4'b0100, 4'b0100, 1'b0));
        cyc("s3_after", 4'b0001, 4'b0000, ex(4'b0001, 4'h0, 4'h0, 4'b0100, 1'b0));
        cyc("s3_clr", 4'b0001, 4'b0100, ex(4'b0001, 4'h0, 4'h0, 4'h0, 1'b0));

        // set and clear in the same cycle: set wins; later clear drops irq
        irq_mask = 4'b0100;
        for (int i = 0; i < 3; i++) cyc("s4_count", 4'b0101, 4'b0000, ex(4'b0001, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s4_rise", 4'b0101, 4'b0000, ex(4'b0101, 4'b0100, 4'h0, 4'h0, 1'b0));
        cyc("s4_set_vs_clr", 4'b0101, 4'b0100, ex(4'b0101, 4'h0, 4'h0, 4'b0100, 1'b1));
        cyc("s4_clr", 4'b0101, 4'b0100, ex(4'b0101, 4'h0, 4'h0, 4'h0, 1'b0));

        // all channels low, then all step high together
        for (int i = 0; i < 3; i++) cyc("s5_down_count", 4'b0000, 4'b0000, ex(4'b0101, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s5_fall", 4'b0000, 4'b0000, ex(4'h0, 4'h0, 4'b0101, 4'h0, 1'b0));
        cyc("s5_fall_cap", 4'b0000, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'b0101, 1'b1));
        cyc("s5_clr_all", 4'b0000, 4'b1111, ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        for (int i = 0; i < 3; i++) cyc("s5_up_count", 4'b1111, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s5_rise_all", 4'b1111, 4'b0000, ex(4'b1111, 4'b1111, 4'h0, 4'h0, 1'b0));
        cyc("s5_cap_all", 4'b1111, 4'b0000, ex(4'b1111, 4'h0, 4'h0, 4'b1111, 1'b1));

        // reset during a ch3 count
        for (int i = 0; i < 3; i++) cyc("s6_down_count", 4'b0000, 4'b0000, ex(4'b1111, 4'h0, 4'h0, 4'b1111, 1'b1));
        cyc("s6_fall_all", 4'b0000, 4'b0000, ex(4'h0, 4'h0, 4'b1111, 4'b1111, 1'b1));
        cyc("s6_idle", 4'b0000, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'b1111, 1'b1));
        cyc("s6_cnt1", 4'b1000, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'b1111, 1'b1));
        cyc("s6_cnt2", 4'b1000, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'b1111, 1'b1));
        reset = 1'b1;
        check_now("s6_async_reset", ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s6_reset_held", 4'b1000, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc("s6_recount", 4'b1000, 4'b0000, ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        cyc("s6_rise", 4'b1000, 4'b0000, ex(4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0));
        cyc("s6_cap", 4'b1000, 4'b0000, ex(4'b1000, 4'h0, 4'h0, 4'b1000, 1'b0));
        irq_mask = 4'b1000;
        check_now("s6_irq", ex(4'b1000, 4'h0, 4'h0, 4'b1000, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Multi-channel debouncer and edge detector for slow external inputs such as push-buttons and slide switches.
- Sits directly downstream of doublesync and consumes its synchronized outdata bus.
- Produces the following per-channel outputs, which feed the CPU-facing PIO/interrupt logic:
  - clean debounced levels;
  - single-cycle rise/fall pulses;
  - a sticky edge-capture register with an interrupt output.

Parameters:
- WIDTH, 4, number of independent input channels.
- CNT_WIDTH, 20, width of each per-channel stability counter.
- DEBOUNCE_CYCLES, 500000, number of consecutive differing samples needed to accept a new level (10 ms at 50 MHz). Legal range is 1 to 2^CNT_WIDTH-1; an elaboration-time check fails otherwise.
- EDGE_TYPE, EDGE_BOTH, edges that set edgecap. Type is edge_type_t: EDGE_RISE, EDGE_FALL or EDGE_BOTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- indata  input  WIDTH  synchronized inputs, taken directly from doublesync outdata. No further synchronization is done here.
- level  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  one-cycle pulse, asserted in the cycle level goes 0->1.
- fall  output  WIDTH  one-cycle pulse, asserted in the cycle level goes 1->0.
- edgecap  output  WIDTH  sticky edge-capture bits.
- edgecap_clr  input  WIDTH  per-bit clear strobe for edgecap, write-1-to-clear, one cycle.
- irq_mask  input  WIDTH  per-bit interrupt enable.
- irq  output  1  OR-reduction of (edgecap & irq_mask).

Behaviour:
- Reset (asynchronous, active-high): all counters 0, level 0, rise 0, fall 0, edgecap 0, irq 0. Level 0 matches the reset value of doublesync.
- Per channel i, on each clk edge:
  - indata[i] == level[i] -> cnt[i] <= 0; no level change.
  - indata[i] != level[i] and cnt[i] < DEBOUNCE_CYCLES-1 -> cnt[i] <= cnt[i]+1.
  - indata[i] != level[i] and cnt[i] == DEBOUNCE_CYCLES-1 -> level[i] <= indata[i]; cnt[i] <= 0; rise[i] or fall[i] <= 1 for exactly that cycle.
- Latency: a clean step is first sampled at edge k; level and the pulse change at edge k+DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1, level is indata delayed by one register.
- Glitch rejection: any sample equal to the current level during counting restarts the count from 0. A bounce shorter than DEBOUNCE_CYCLES never alters level and never pulses.
- rise and fall are registered, mutually exclusive per channel, and never asserted in consecutive cycles for the same channel. The exception is DEBOUNCE_CYCLES=1, where a toggling input may pulse every cycle.
- The counter saturates by construction: it never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- edgecap[i] set condition (set_i):
  - EDGE_RISE: rise[i].
  - EDGE_FALL: fall[i].
  - EDGE_BOTH: rise[i] | fall[i].
- edgecap[i] update:
  - set_i -> edgecap[i] <= 1.
  - else edgecap_clr[i] -> edgecap[i] <= 0.
  - else hold.
  - Set uses the same-cycle registered pulse, so edgecap lags rise/fall by one cycle.
  - Simultaneous set and clear -> set wins, so no event is lost.
- irq is combinational from registered edgecap and the irq_mask input. It has no added latency beyond the edgecap register.
- Reset asserted mid-count or mid-pulse clears everything immediately. After release, a held-high input is re-accepted after DEBOUNCE_CYCLES samples and produces a rise.
- Channels are fully independent; simultaneous events on several channels are all captured.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum edge_type_t {EDGE_RISE, EDGE_FALL, EDGE_BOTH};
  - localparam DEFAULT_DEBOUNCE_CYCLES = 500000.
- Sub-module debounce_chan holds the single-channel counter, level and rise/fall registers, with parameters CNT_WIDTH and DEBOUNCE_CYCLES. It is instantiated WIDTH times in a generate loop.
- The top level holds the edgecap, clear and irq logic.

Test Plan:
(all scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=EDGE_BOTH)
- Reset, then indata=4'b0001 held -> level[0]=1 exactly 3 cycles after the first sample edge; rise=4'b0001 for one cycle; edgecap=4'b0001 one cycle later; irq=1 with irq_mask=4'b0001, irq=0 with irq_mask=0.
- indata[1] pulses 1-0-1-0 with 2-cycle highs -> level[1] stays 0; rise[1] and fall[1] never assert; edgecap[1] stays 0.
- Level 1 on ch2, then indata[2]=0 with a one-cycle return to 1 on the 3rd low cycle -> counter restarts; fall[2] occurs 4 samples after the final 1->0 transition, not before.
- edgecap=4'b0100 with edgecap_clr=4'b0100 pulsed in the same cycle as a new set_2 -> edgecap[2] remains 1; a clear pulse one cycle later -> edgecap[2]=0 and irq deasserts the same cycle.
- All four channels stepped 0->1 simultaneously -> rise=4'b1111 in one cycle; edgecap=4'b1111.
- Reset asserted 2 cycles into a count on ch3 -> level, rise, cnt and edgecap go 0 asynchronously; after release, indata[3]=1 held -> rise[3] after 4 samples.
